stream_demultiplexer: RTL and testbench
=======================================

Name: stream_demultiplexer

Overview:
- Registered, valid/ready-handshaked successor of the combinational demultiplexer.
- Routes a packetised stream (data + last) from one input to one of NUMBER_OF_OUTPUTS outputs.
- Destination is locked per packet; packets addressed to a nonexistent output are discarded and counted.
- Sits between a single producer (bus/DMA front end) and per-channel consumers; one slot of buffering; full throughput.

Parameters:
- DATA_WIDTH, 8, width of data beat.
- INACTIVE_VALUE, 0, value driven on outputData of every channel not currently presenting a valid beat.
- NUMBER_OF_OUTPUTS, 4, output channel count (>=2).
- SELECT_WIDTH, $clog2(NUMBER_OF_OUTPUTS)+1, select width; the extra bit allows out-of-range codes.
- COUNTER_WIDTH, 16, width of droppedPackets counter.

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- inputData  input  DATA_WIDTH  beat data.
- inputLast  input  1  final beat of packet.
- inputValid  input  1  producer has a beat.
- inputReady  output  1  block accepts beat this cycle.
- select  input  SELECT_WIDTH  destination; sampled only on the first beat of a packet.
- outputData  output  DATA_WIDTH x NUMBER_OF_OUTPUTS  unpacked array, per-channel data.
- outputLast  output  NUMBER_OF_OUTPUTS  per-channel last.
- outputValid  output  NUMBER_OF_OUTPUTS  per-channel valid; at most one bit set.
- outputReady  input  NUMBER_OF_OUTPUTS  per-channel consumer ready.
- busy  output  1  high while a packet is in progress (LOCKED/DROPPING) or the slot is occupied.
- droppedPackets  output  COUNTER_WIDTH  saturating count of discarded packets.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state=IDLE, slot empty, outputValid=0, outputLast=0.
  - every outputData=INACTIVE_VALUE, droppedPackets=0, busy=0.
- Handshakes:
  - A beat transfers when valid && ready are both high at a rising edge.
  - Producer must hold inputData, inputLast and select stable while inputValid && !inputReady.
  - outputValid, once high, stays high with data stable until outputReady[dest] is seen.
- Slot: one register holding {data, last, dest}.
  - outputValid[dest]=slotFull; all other channels are inactive.
  - Inactive channels drive outputValid=0, outputLast=0, outputData=INACTIVE_VALUE.
- Latency: a beat accepted at edge N appears on outputs after edge N (1 cycle). No combinational path from inputData to outputData.
- State machine (effective destination):
  - IDLE: the destination of an accepted beat is select.
    - select < NUMBER_OF_OUTPUTS: beat enters the slot; if !inputLast, latch dest and go to LOCKED.
    - select >= NUMBER_OF_OUTPUTS: beat is discarded. If inputLast, droppedPackets++ and stay in IDLE; else go to DROPPING.
  - LOCKED: select is ignored; beats go to the latched dest. An accepted last beat returns to IDLE.
  - DROPPING: every beat is accepted and discarded. An accepted last beat increments droppedPackets and returns to IDLE.
- inputReady:
  - DROPPING, or IDLE with select out of range: 1.
  - Otherwise: !slotFull || outputReady[slotDest]. This is combinational from outputReady and gives full throughput.
- Simultaneous drain and fill: slot drains and reloads in the same edge. No bubble, no duplication.
- Back-to-back packets: a new packet's first beat may be accepted in the cycle after the previous last beat. Its select is sampled even while the previous last beat is still in the slot. The slot may hand over to a different channel on the next edge.
- Counter: droppedPackets saturates at all-ones and never wraps.
- Reset mid-packet: the partial packet and any slot contents are lost. No count. The next beat is treated as a first beat.
- Ready on an idle channel, or a change of select while LOCKED: no effect.

Test Plan:
- Single-beat routing: select=2, data=0xA5, last=1, all ready=1 -> cycle+1: outputValid=4'b0100, outputData[2]=0xA5, outputLast[2]=1; other channels 0x00; busy falls after drain.
- Packet lock: 4-beat packet 0x10..0x13 with select=1 on beat 0, select toggled to 3 on beats 1-3 -> all four beats only on channel 1, last on 0x13, state IDLE afterwards.
- Backpressure: outputReady[0]=0 for 5 cycles during a 3-beat packet -> inputReady=0 while slot is full; data held stable; no beats lost or duplicated; throughput is 1 beat/cycle once ready=1.
- Drop and count: select=7 (N=4), 3-beat packet, then select=4 single-beat -> inputReady=1 throughout; no outputValid; droppedPackets=2.
- Saturation: COUNTER_WIDTH=2, 5 dropped packets -> droppedPackets=3.
- Back-to-back and reset: packet A to ch0 (last), next-cycle packet B to ch3 -> no bubble. Then assert reset mid-B -> next cycle all outputValid=0, busy=0, counter=0; the following beat with select=1 is routed to ch1.

Source files
------------

// File: rtl/stream_demultiplexer.sv
// stream_demultiplexer
// Routes a packetised valid/ready stream (data + last) from one producer to one
// of NUMBER_OF_OUTPUTS consumers through a single-entry output slot. The
// destination is sampled on the first beat of each packet and held until the
// last beat. Packets addressed to a nonexistent output are swallowed and
// counted in a saturating counter.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   inputData/Last      beat payload from the producer
//   inputValid/Ready    producer handshake (inputReady is combinational)
//   select              destination, sampled only on a packet's first beat
//   outputData[N]       per-channel data, INACTIVE_VALUE when not presenting
//   outputLast/Valid    per-channel last / valid (at most one valid bit set)
//   outputReady         per-channel consumer ready
//   busy                packet in progress or slot occupied
//   droppedPackets      saturating count of discarded packets
module stream_demultiplexer #(
  parameter int unsigned           DATA_WIDTH        = 8,
  parameter logic [DATA_WIDTH-1:0] INACTIVE_VALUE    = '0,
  parameter int unsigned           NUMBER_OF_OUTPUTS = 4,
  parameter int unsigned           SELECT_WIDTH      = $clog2(NUMBER_OF_OUTPUTS) + 1,
  parameter int unsigned           COUNTER_WIDTH     = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        inputData,
  input  logic                         inputLast,
  input  logic                         inputValid,
  output logic                         inputReady,
  input  logic [SELECT_WIDTH-1:0]      select,
  output logic [DATA_WIDTH-1:0]        outputData [NUMBER_OF_OUTPUTS],
  output logic [NUMBER_OF_OUTPUTS-1:0] outputLast,
  output logic [NUMBER_OF_OUTPUTS-1:0] outputValid,
  input  logic [NUMBER_OF_OUTPUTS-1:0] outputReady,
  output logic                         busy,
  output logic [COUNTER_WIDTH-1:0]     droppedPackets
);

  localparam int unsigned DEST_WIDTH = $clog2(NUMBER_OF_OUTPUTS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCKED   = 2'd1,
    DROPPING = 2'd2
  } stateType;

  stateType state;
  stateType nextState;

  logic                  slotFull;
  logic [DATA_WIDTH-1:0] slotData;
  logic                  slotLast;
  logic [DEST_WIDTH-1:0] slotDest;
  logic [DEST_WIDTH-1:0] lockedDest;

  logic                  selectInRange;
  logic                  dropBeat;
  logic                  slotDrain;
  logic                  accept;
  logic [DEST_WIDTH-1:0] effectiveDest;

  // Handshake and routing decisions for the beat currently offered
  always_comb begin
    selectInRange = select < SELECT_WIDTH'(NUMBER_OF_OUTPUTS);
    dropBeat      = (state == DROPPING) || ((state == IDLE) && !selectInRange);
    slotDrain     = slotFull && outputReady[slotDest];
    // A draining slot can be refilled in the same edge, so no bubble
    inputReady    = dropBeat || !slotFull || slotDrain;
    accept        = inputValid && inputReady;
    effectiveDest = (state == LOCKED) ? lockedDest : select[DEST_WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic: the first beat of a packet decides lock vs. drop
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept && !inputLast) nextState = selectInRange ? LOCKED : DROPPING;
      end
      LOCKED, DROPPING: begin
        if (accept && inputLast) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Output slot and latched packet destination
  always_ff @(posedge clock) begin
    if (reset) begin
      slotFull   <= 1'b0;
      slotData   <= INACTIVE_VALUE;
      slotLast   <= 1'b0;
      slotDest   <= '0;
      lockedDest <= '0;
    end else begin
      if (accept && !dropBeat) begin
        slotFull <= 1'b1;
        slotData <= inputData;
        slotLast <= inputLast;
        slotDest <= effectiveDest;
      end else if (slotDrain) begin
        slotFull <= 1'b0;
      end
      if ((state == IDLE) && accept && !dropBeat && !inputLast) lockedDest <= effectiveDest;
    end
  end

  // Saturating count of discarded packets, bumped on their last beat
  always_ff @(posedge clock) begin
    if (reset) begin
      droppedPackets <= '0;
    end else if (accept && dropBeat && inputLast && (droppedPackets != '1)) begin
      droppedPackets <= droppedPackets + COUNTER_WIDTH'(1);
    end
  end

  // Present the slot on its destination channel; all others stay inactive
  always_comb begin
    for (int i = 0; i < NUMBER_OF_OUTPUTS; i++) begin
      outputValid[i] = slotFull && (slotDest == DEST_WIDTH'(i));
      outputLast[i]  = outputValid[i] && slotLast;
      outputData[i]  = outputValid[i] ? slotData : INACTIVE_VALUE;
    end
  end

  assign busy = (state != IDLE) || slotFull;

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Directed self-checking bench for stream_demultiplexer (N=4, 2-bit counter).
module tb_stream_demultiplexer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] inputData;
  logic       inputLast;
  logic       inputValid;
  logic       inputReady;
  logic [2:0] select;
  logic [7:0] outputData [4];
  logic [3:0] outputLast;
  logic [3:0] outputValid;
  logic [3:0] outputReady;
  logic       busy;
  logic [1:0] droppedPackets;

  int checks = 0;
  int errors = 0;

  stream_demultiplexer #(
    .DATA_WIDTH(8),
    .INACTIVE_VALUE(8'h00),
    .NUMBER_OF_OUTPUTS(4),
    .SELECT_WIDTH(3),
    .COUNTER_WIDTH(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .inputData(inputData),
    .inputLast(inputLast),
    .inputValid(inputValid),
    .inputReady(inputReady),
    .select(select),
    .outputData(outputData),
    .outputLast(outputLast),
    .outputValid(outputValid),
    .outputReady(outputReady),
    .busy(busy),
    .droppedPackets(droppedPackets)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic [2:0] s);
    inputValid = v;
    inputData  = d;
    inputLast  = l;
    select     = s;
  endtask

  initial begin
    reset       = 1'b1;
    outputReady = 4'hF;
    drive(1'b0, 8'h00, 1'b0, 3'd0);
    cyc(); cyc();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_valid", 32'(outputValid), 32'h0);
    check("rst_last", 32'(outputLast), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dropped", 32'(droppedPackets), 32'h0);
    check("rst_data2", 32'(outputData[2]), 32'h0);
    check("rst_ready", 32'(inputReady), 32'h1);

    // Single-beat routing to channel 2
    drive(1'b1, 8'hA5, 1'b1, 3'd2);
    #1;
    check("single_ready", 32'(inputReady), 32'h1);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 3'd0);
    #1;
    check("single_valid", 32'(outputValid), 32'h4);
    check("single_data2", 32'(outputData[2]), 32'hA5);
    check("single_last", 32'(outputLast), 32'h4);
    check("single_data0", 32'(outputData[0]), 32'h00);
    check("single_busy", 32'(busy), 32'h1);
    cyc();
    check("single_drained", 32'(outputValid), 32'h0);
    check("single_busy_low", 32'(busy), 32'h0);

    // Packet lock: select changes after the first beat must be ignored
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h10 + i), i == 3, (i == 0) ? 3'd1 : 3'd3);
      #1;
      check("lock_ready", 32'(inputReady), 32'h1);
      cyc();
      check("lock_valid", 32'(outputValid), 32'h2);
      check("lock_data1", 32'(outputData[1]), 32'(8'h10 + i));
      check("lock_last", 32'(outputLast), (i == 3) ? 32'h2 : 32'h0);
      check("lock_data3", 32'(outputData[3]), 32'h0);
    end
    drive(1'b0, 8'h00, 1'b0, 3'd0);
    cyc();
    check("lock_idle_valid", 32'(outputValid), 32'h0);
    check("lock_idle_busy", 32'(busy), 32'h0);

    // Backpressure on channel 0 for five cycles
    outputReady = 4'b1110;
    drive(1'b1, 8'h20, 1'b0, 3'd0);
    #1;
    check("bp_ready0", 32'(inputReady), 32'h1);
    cyc();
    drive(1'b1, 8'h21, 1'b0, 3'd0);
    #1;
    check("bp_stall_ready", 32'(inputReady), 32'h0);
    check("bp_stall_data", 32'(outputData[0]), 32'h20);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("bp_hold_ready", 32'(inputReady), 32'h0);
      check("bp_hold_data", 32'(outputData[0]), 32'h20);
      check("bp_hold_valid", 32'(outputValid), 32'h1);
    end
    outputReady = 4'hF;
    #1;
    check("bp_release_ready", 32'(inputReady), 32'h1);
    cyc();
    check("bp_beat1", 32'(outputData[0]), 32'h21);
    check("bp_beat1_last", 32'(outputLast), 32'h0);
    drive(1'b1, 8'h22, 1'b1, 3'd2);
    #1;
    check("bp_beat2_ready", 32'(inputReady), 32'h1);
    cyc();
    check("bp_beat2", 32'(outputData[0]), 32'h22);
    check("bp_beat2_last", 32'(outputLast), 32'h1);
    drive(1'b0, 8'h00, 1'b0, 3'd0);
    cyc();
    check("bp_idle_valid", 32'(outputValid), 32'h0);
    check("bp_idle_busy", 32'(busy), 32'h0);

    // Drop a 3-beat packet to select=7, then a single beat to select=4
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h30 + i), i == 2, (i == 0) ? 3'd7 : 3'd1);
      #1;
      check("drop_ready", 32'(inputReady), 32'h1);
      cyc();
      check("drop_valid", 32'(outputValid), 32'h0);
      check("drop_busy", 32'(busy), (i < 2) ? 32'h1 : 32'h0);
    end
    check("drop_count1", 32'(droppedPackets), 32'h1);
    drive(1'b1, 8'h40, 1'b1, 3'd4);
    #1;
    check("drop4_ready", 32'(inputReady), 32'h1);
    cyc();
    check("drop4_valid", 32'(outputValid), 32'h0);
    check("drop_count2", 32'(droppedPackets), 32'h2);

    // Saturation of the 2-bit counter after five drops
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h41, 1'b1, 3'd5);
      cyc();
      check("sat_count", 32'(droppedPackets), 32'h3);
    end
    drive(1'b0, 8'h00, 1'b0, 3'd0);
    cyc();

    // Back-to-back packets to different channels, then reset mid-packet
    drive(1'b1, 8'h50, 1'b1, 3'd0);
    cyc();
    drive(1'b1, 8'h60, 1'b0, 3'd3);
    #1;
    check("b2b_ready", 32'(inputReady), 32'h1);
    check("b2b_a_valid", 32'(outputValid), 32'h1);
    check("b2b_a_data", 32'(outputData[0]), 32'h50);
    cyc();
    check("b2b_b_valid", 32'(outputValid), 32'h8);
    check("b2b_b_data", 32'(outputData[3]), 32'h60);
    drive(1'b1, 8'h61, 1'b0, 3'd3);
    cyc();
    check("b2b_b1_data", 32'(outputData[3]), 32'h61);
    drive(1'b0, 8'h00, 1'b0, 3'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("midrst_valid", 32'(outputValid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_count", 32'(droppedPackets), 32'h0);
    drive(1'b1, 8'h70, 1'b1, 3'd1);
    cyc();
    check("postrst_valid", 32'(outputValid), 32'h2);
    check("postrst_data", 32'(outputData[1]), 32'h70);
    drive(1'b0, 8'h00, 1'b0, 3'd0);
    cyc();
    check("postrst_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
